// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares a byte-wide RAM port between instruction fetch and
//            load/store, serialising accesses into little-endian byte beats.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    input  logic              if_flush_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [1:0]        mem_len_i,
    input  logic              mem_sext_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i,
    output logic              ram_wr_o,
    output logic              if_halt_o,
    output logic              mem_halt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_next;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_len;
    logic              r_sext;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic              r_if_done;
    logic              r_mem_done;
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;

    logic              w_accept_mem;
    logic              w_accept_if;
    logic              w_finish;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_wbyte;
    logic [1:0]        w_lane;
    logic [31:0]       w_assembled;
    logic [31:0]       w_load_result;
    logic [2:0]        w_mem_len_n;
    logic              w_unused;

    assign w_unused    = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};
    assign w_addr      = r_base + ADDR_W'(r_cnt);
    assign w_lane      = 2'(r_cnt - 3'd1);
    assign w_mem_len_n = (mem_len_i == 2'd0) ? 3'd1 :
                         (mem_len_i == 2'd1) ? 3'd2 : 3'd4;

    always_comb begin
        w_wbyte = 8'h00;
        case (r_cnt[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    // The byte arriving now belongs to the address driven one beat earlier.
    always_comb begin
        w_assembled = r_buf;
        case (w_lane)
            2'd0:    w_assembled[7:0]   = ram_din_i;
            2'd1:    w_assembled[15:8]  = ram_din_i;
            2'd2:    w_assembled[23:16] = ram_din_i;
            default: w_assembled[31:24] = ram_din_i;
        endcase
    end

    always_comb begin
        w_load_result = w_assembled;
        case (r_len)
            3'd1:    w_load_result = {{24{r_sext & w_assembled[7]}},  w_assembled[7:0]};
            3'd2:    w_load_result = {{16{r_sext & w_assembled[15]}}, w_assembled[15:0]};
            default: w_load_result = w_assembled;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 3'd1;
        w_accept_mem = 1'b0;
        w_accept_if  = 1'b0;
        w_finish     = 1'b0;
        ram_addr_o   = '0;
        ram_dout_o   = 8'h00;
        ram_wr_o     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = 3'd0;
                // A requester whose done is showing has not dropped its request yet.
                if (mem_req_i && !r_mem_done) begin
                    w_accept_mem = 1'b1;
                    w_state_next = mem_we_i ? STORE : LOAD;
                end else if (if_req_i && !r_if_done) begin
                    w_accept_if  = 1'b1;
                    w_state_next = FETCH;
                end
            end
            FETCH, LOAD: begin
                if (r_cnt < r_len) begin
                    ram_addr_o = w_addr;
                end
                if (r_state == FETCH && if_flush_i) begin
                    w_state_next = IDLE;
                end else if (r_cnt == r_len) begin
                    w_finish     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            STORE: begin
                ram_addr_o = w_addr;
                ram_dout_o = w_wbyte;
                ram_wr_o   = 1'b1;
                if (r_cnt == r_len - 3'd1) begin
                    w_finish     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_base      <= '0;
            r_len       <= 3'd0;
            r_sext      <= 1'b0;
            r_wdata     <= 32'h0;
            r_buf       <= 32'h0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_data   <= 32'h0;
            r_mem_rdata <= 32'h0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            if (w_accept_mem) begin
                r_base  <= mem_addr_i[ADDR_W-1:0];
                r_len   <= w_mem_len_n;
                r_sext  <= mem_sext_i;
                r_wdata <= mem_wdata_i;
                r_buf   <= 32'h0;
            end else if (w_accept_if) begin
                r_base  <= if_addr_i[ADDR_W-1:0];
                r_len   <= 3'd4;
                r_sext  <= 1'b0;
                r_buf   <= 32'h0;
            end else if ((r_state == FETCH || r_state == LOAD) && r_cnt != 3'd0) begin
                r_buf <= w_assembled;
            end
            if (w_finish) begin
                case (r_state)
                    FETCH: begin
                        r_if_done <= 1'b1;
                        r_if_data <= w_assembled;
                    end
                    LOAD: begin
                        r_mem_done  <= 1'b1;
                        r_mem_rdata <= w_load_result;
                    end
                    STORE:   r_mem_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign if_done_o   = r_if_done;
    assign if_data_o   = r_if_data;
    assign mem_done_o  = r_mem_done;
    assign mem_rdata_o = r_mem_rdata;
    assign if_halt_o   = if_req_i & ~r_if_done & ~if_flush_i;
    assign mem_halt_o  = mem_req_i & ~r_mem_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a byte RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int          ADDR_W = 17;
    localparam logic [31:0] AMASK  = 32'h0001_FFFF;
    localparam logic [1:0]  K_FETCH = 2'd0;
    localparam logic [1:0]  K_LOAD  = 2'd1;
    localparam logic [1:0]  K_STORE = 2'd2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = 32'h0;
    logic              if_flush = 1'b0;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [31:0]       mem_addr = 32'h0;
    logic [1:0]        mem_len = 2'd0;
    logic              mem_sext = 1'b0;
    logic [31:0]       mem_wdata = 32'h0;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              ram_wr;
    logic              if_halt;
    logic              mem_halt;
    logic              ram_clear = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] if_q[$];
    logic [32:0] mem_q[$];
    logic [24:0] wr_q[$];

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [1:0]  len;
        logic        sext;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_flush_i (if_flush),
        .if_data_o  (if_data),
        .if_done_o  (if_done),
        .mem_req_i  (mem_req),
        .mem_we_i   (mem_we),
        .mem_addr_i (mem_addr),
        .mem_len_i  (mem_len),
        .mem_sext_i (mem_sext),
        .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata),
        .mem_done_o (mem_done),
        .ram_addr_o (ram_addr),
        .ram_dout_o (ram_dout),
        .ram_din_i  (ram_din),
        .ram_wr_o   (ram_wr),
        .if_halt_o  (if_halt),
        .mem_halt_o (mem_halt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h020: return 8'h80;
            32'h021: return 8'hFF;
            32'h040: return 8'h80;
            32'h2FF: return 8'hAA;
            32'h200: return 8'h37;
            32'h201: return 8'h12;
            default: return 8'h00;
        endcase
    endfunction

    // Synchronous byte RAM: read data appears the cycle after its address.
    logic [7:0] ram [0:131071];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 131072; i++) ram[i] <= init_byte(i);
        end else begin
            ram_din <= ram[ram_addr];
            if (ram_wr) ram[ram_addr] <= ram_dout;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pops expectations when the DUT reports completion or writes.
    always @(negedge clk) begin
        logic [32:0] me;
        logic [24:0] we;
        if (if_done) begin
            if (if_q.size() == 0) chk("if_done_unexpected", {31'h0, if_done}, 32'h0);
            else chk("if_data", if_data, if_q.pop_front());
        end
        if (mem_done) begin
            if (mem_q.size() == 0) chk("mem_done_unexpected", {31'h0, mem_done}, 32'h0);
            else begin
                me = mem_q.pop_front();
                if (me[32]) chk("mem_rdata", mem_rdata, me[31:0]);
            end
        end
        if (ram_wr) begin
            if (wr_q.size() == 0) chk("ram_write_unexpected", {7'h0, ram_addr, ram_dout}, 32'h0);
            else begin
                we = wr_q.pop_front();
                chk("ram_write", {7'h0, ram_addr, ram_dout}, {7'h0, we});
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int  nb;
        int  k;
        bit  got;
        logic is_st;
        is_st = (v.kind == K_STORE);
        nb = (v.kind == K_FETCH) ? 4 : (v.len == 2'd0) ? 1 : (v.len == 2'd1) ? 2 : 4;
        if (v.kind == K_FETCH) begin
            if_q.push_back(v.exp);
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            mem_q.push_back({v.kind == K_LOAD, v.exp});
            if (is_st) begin
                for (int i = 0; i < nb; i++)
                    wr_q.push_back({17'((v.addr + 32'(i)) & AMASK), v.wdata[8*i +: 8]});
            end
            mem_req   = 1'b1;
            mem_we    = is_st;
            mem_addr  = v.addr;
            mem_len   = v.len;
            mem_sext  = v.sext;
            mem_wdata = v.wdata;
        end
        got = 1'b0;
        k   = 0;
        while (!got && k <= 20) begin
            @(negedge clk);
            if (k >= 1 && k <= nb) begin
                chk("ram_addr", {15'h0, ram_addr}, (v.addr + 32'(k - 1)) & AMASK);
                chk("ram_wr", {31'h0, ram_wr}, {31'h0, is_st});
            end
            chk("halt", {31'h0, (v.kind == K_FETCH) ? if_halt : mem_halt},
                (k < v.lat) ? 32'h1 : 32'h0);
            if ((v.kind == K_FETCH) ? if_done : mem_done) begin
                got = 1'b1;
                chk("latency", 32'(k), 32'(v.lat));
                chk("bus_idle_at_done", {14'h0, ram_wr, ram_addr}, 32'h0);
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        if (!got) chk("done_timeout", 32'h0, 32'h1);
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   mem_k;
        int   if_k;
        int   n_if;
        logic [31:0] a5;
        vec_t v2;

        vecs[0]  = '{K_FETCH, 32'h0000_0100, 2'd2, 1'b0, 32'h0,         32'h0010_0513, 6};
        vecs[1]  = '{K_LOAD,  32'h0000_0040, 2'd0, 1'b0, 32'h0,         32'h0000_0080, 3};
        vecs[2]  = '{K_LOAD,  32'h0000_0040, 2'd0, 1'b1, 32'h0,         32'hFFFF_FF80, 3};
        vecs[3]  = '{K_LOAD,  32'h0000_0020, 2'd1, 1'b1, 32'h0,         32'hFFFF_FF80, 4};
        vecs[4]  = '{K_LOAD,  32'h0000_0020, 2'd1, 1'b0, 32'h0,         32'h0000_FF80, 4};
        vecs[5]  = '{K_STORE, 32'h0001_FFFF, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0,         5};
        vecs[6]  = '{K_LOAD,  32'h0001_FFFF, 2'd3, 1'b0, 32'h0,         32'hDEAD_BEEF, 6};
        vecs[7]  = '{K_STORE, 32'h0000_0300, 2'd1, 1'b0, 32'h1234_5678, 32'h0,         3};
        vecs[8]  = '{K_LOAD,  32'h0000_02FF, 2'd2, 1'b0, 32'h0,         32'h0056_78AA, 6};
        vecs[9]  = '{K_FETCH, 32'hFFFE_0100, 2'd2, 1'b0, 32'h0,         32'h0010_0513, 6};
        vecs[10] = '{K_STORE, 32'h0000_0040, 2'd0, 1'b0, 32'h1122_33CC, 32'h0,         2};
        vecs[11] = '{K_LOAD,  32'h0000_0040, 2'd0, 1'b1, 32'h0,         32'hFFFF_FFCC, 3};

        repeat (3) @(posedge clk);
        ram_clear = 1'b0;
        @(negedge clk);
        chk("reset_dones", {30'h0, if_done, mem_done}, 32'h0);
        chk("reset_if_data", if_data, 32'h0);
        chk("reset_mem_rdata", mem_rdata, 32'h0);
        chk("reset_bus", {6'h0, ram_wr, ram_dout, ram_addr}, 32'h0);
        chk("reset_halts", {30'h0, if_halt, mem_halt}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_txn(vecs[i]);

        // Simultaneous requests: load wins, fetch is accepted in the load's done cycle.
        if_q.push_back(32'h0010_0513);
        mem_q.push_back({1'b1, 32'hFFFF_FF80});
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20; mem_len = 2'd1; mem_sext = 1'b1;
        mem_k = -1; if_k = -1; a5 = 32'hFFFF_FFFF;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 5) a5 = {15'h0, ram_addr};
            if (mem_done && mem_k < 0) begin mem_k = k; mem_req = 1'b0; end
            if (if_done && if_k < 0) begin if_k = k; if_req = 1'b0; end
            @(posedge clk); #1;
        end
        chk("arb_mem_done_cycle", 32'(mem_k), 32'd4);
        chk("arb_if_done_cycle", 32'(if_k), 32'd10);
        chk("arb_fetch_first_addr", a5, 32'h100);

        // Flush two cycles into a fetch: no done, port idle the next cycle.
        if_req = 1'b1; if_addr = 32'h100;
        n_if = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) if_flush = 1'b1;
            if (k == 3) begin if_flush = 1'b0; if_req = 1'b0; end
            @(negedge clk);
            if (k == 2) chk("flush_halt", {31'h0, if_halt}, 32'h0);
            if (k == 3) chk("flush_idle_addr", {15'h0, ram_addr}, 32'h0);
            if (if_done) n_if++;
            @(posedge clk); #1;
        end
        chk("flush_no_done", 32'(n_if), 32'h0);
        v2 = '{K_FETCH, 32'h0000_0200, 2'd2, 1'b0, 32'h0, 32'h0000_1237, 6};
        run_txn(v2);

        // Reset for two cycles in the middle of a fetch.
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_dones", {30'h0, if_done, mem_done}, 32'h0);
        chk("midreset_if_data", if_data, 32'h0);
        chk("midreset_mem_rdata", mem_rdata, 32'h0);
        chk("midreset_bus", {6'h0, ram_wr, ram_dout, ram_addr}, 32'h0);
        @(posedge clk); #1;
        run_txn(vecs[0]);

        repeat (3) @(posedge clk);
        chk("if_q_drained", 32'(if_q.size()), 32'h0);
        chk("mem_q_drained", 32'(mem_q.size()), 32'h0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM port and shares it between two requesters: instruction fetch (IF stage) and load/store (MEM stage).
- Serialises each 8/16/32-bit access into byte transfers, little-endian, and reassembles read words.
- Raises per-requester halt requests to the ctrl unit while an access is outstanding.
- Sits between the pipeline stages and the external RAM pins.

Parameters:
- ADDR_W, 17, width of RAM byte address; request addresses are truncated to this width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_done_o
- if_addr_i  in  32  fetch byte address
- if_flush_i  in  1  PC redirect; aborts an in-progress fetch
- if_data_o  out  32  fetched instruction
- if_done_o  out  1  one-cycle pulse; if_data_o valid
- mem_req_i  in  1  load/store request, held until mem_done_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  data byte address
- mem_len_i  in  2  0 = byte, 1 = half, 2/3 = word
- mem_sext_i  in  1  sign-extend load result
- mem_wdata_i  in  32  store data, low bytes used
- mem_rdata_o  out  32  load result
- mem_done_o  out  1  one-cycle pulse; load data valid / store complete
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte; valid the cycle after its address
- ram_wr_o  out  1  1 = write this cycle
- if_halt_o  out  1  = if_req_i & ~if_done_o & ~if_flush_i
- mem_halt_o  out  1  = mem_req_i & ~mem_done_o

Behaviour:
- State machine: IDLE, FETCH, LOAD, STORE. The byte counter cnt is 3 bits; N = access length in bytes (1, 2 or 4; fetch always 4).
- Reset (rst = 0 at a clock edge):
  - state goes to IDLE; all registered outputs go to 0.
  - An access in progress is abandoned; a partially written store stays partial.
- IDLE arbitration:
  - A request is sampled in cycle T. mem_req_i has priority over if_req_i.
  - The winner's address, length, sext and wdata are latched at the end of cycle T; cnt = 0.
- A requester whose done is high in the current cycle is ignored for arbitration in that cycle. This prevents re-accepting a request that has not yet dropped.
- LOAD/FETCH timing:
  - Cycles T+1 .. T+N drive ram_addr_o = (base + cnt) mod 2^ADDR_W, with ram_wr_o = 0.
  - The byte for address k is captured from ram_din_i in the following cycle into lane k.
  - Done pulses in cycle T+N+2 together with the data, and state returns to IDLE in that cycle. Total latency is N+2 cycles from request.
- STORE timing:
  - Cycles T+1 .. T+N drive ram_addr_o = base + cnt, ram_dout_o = wdata byte cnt, and ram_wr_o = 1.
  - mem_done_o pulses in cycle T+N+1.
- Load result:
  - byte: sext ? {24{b0[7]}, b0} : {24'b0, b0}.
  - half: same rule using bit 15.
  - word: the 32 bits as assembled.
- Outputs hold values: if_data_o and mem_rdata_o hold their last value between dones.
- Bus defaults when not transferring: ram_wr_o = 0, ram_dout_o = 0, ram_addr_o = 0.
- if_flush_i during FETCH:
  - Go to IDLE next cycle; no if_done_o; the fetch is discarded.
  - A flush in IDLE, or during LOAD/STORE, has no effect on the port.
- No preemption: a fetch in progress completes (unless flushed) even if mem_req_i rises. mem_req_i then wins at the next IDLE cycle.
- Misalignment is allowed; bytes are simply sequential.
- Address wraps at 2^ADDR_W - 1 to 0.

Test Plan:
- Reset: rst = 0 for 2 cycles mid-FETCH -> all outputs 0, state IDLE; next if_req_i is accepted normally.
- Fetch: RAM[0x100..0x103] = 13, 05, 10, 00; if_req_i at 0x100 in cycle T -> addresses 0x100..0x103 in T+1..T+4, if_done_o in T+6 with if_data_o = 0x00100513, if_halt_o high in T..T+5.
- Arbitration: if_req_i and mem_req_i both high in IDLE; load half at 0x20 with RAM = 0x80, 0xFF, sext = 1 -> mem_done_o first with mem_rdata_o = 0xFFFFFF80; fetch starts the cycle after mem_done_o.
- Store word 0xDEADBEEF at 0x1FFFF (ADDR_W = 17) -> writes EF@0x1FFFF, BE@0x0, AD@0x1, DE@0x2; mem_done_o in T+5.
- Flush: if_flush_i in T+2 of a fetch -> no if_done_o, IDLE at T+3; a new fetch at 0x200 completes correctly.
- Load byte 0x80 with sext = 0 -> mem_rdata_o = 0x00000080, mem_done_o in T+3.
